// File: rtl/mcu_irq_ctrl_if.sv
// ============================================================================
// Module   : mcu_irq_ctrl_if
// Purpose  : Event-source / sysctrl signal bundle for the MCU interrupt controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mcu_irq_ctrl_if #(
  parameter int NUM_SRC = 7
);
  logic [NUM_SRC-1:0] src_in;
  logic [NUM_SRC-1:0] src_en;
  logic [NUM_SRC-1:0] src_ack;
  logic [NUM_SRC-1:0] overrun;
  logic [7:0]         int_in;
  logic [7:0]         int_ack;

  // master: event sources plus sysctrl; slave: the interrupt controller
  modport master (
    output src_in, src_en, int_ack,
    input  int_in, src_ack, overrun
  );

  modport slave (
    input  src_in, src_en, int_ack,
    output int_in, src_ack, overrun
  );
endinterface

`default_nettype wire

// File: rtl/mcu_irq_ctrl.sv
// ============================================================================
// Module   : mcu_irq_ctrl
// Purpose  : Latches source events into sysctrl int_in[7:1], clears them on ack.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mcu_irq_ctrl #(
  parameter int           NUM_SRC   = 7,
  parameter logic [6:0]   EDGE_MODE = 7'h7F,
  parameter int           HOLDOFF   = 16
) (
  input  wire            clk,
  input  wire            reset,
  mcu_irq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] pend_vec;
  logic [NUM_SRC-1:0] ack_vec;
  logic [NUM_SRC-1:0] ovr_vec;
  logic [7:0]         int_vec;
  logic               unused_ack;

  // one-cycle history for edge detection; zero at reset so a high input fires once
  always_ff @(posedge clk) begin
    if (reset) begin
      src_d <= '0;
    end else begin
      src_d <= bus.src_in;
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    localparam bit IS_EDGE = EDGE_MODE[k];

    state_t     state;
    logic [7:0] cnt;
    logic       pend_q;
    logic       sack_q;
    logic       ovr_q;
    logic       ev;
    logic       ack;

    assign ev  = bus.src_en[k] & (IS_EDGE ? (bus.src_in[k] & ~src_d[k]) : bus.src_in[k]);
    assign ack = bus.int_ack[k+1];

    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= IDLE;
        cnt    <= 8'd0;
        pend_q <= 1'b0;
        sack_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        sack_q <= 1'b0;
        if (!bus.src_en[k]) begin
          // disable overrides everything; overrun history survives
          state  <= IDLE;
          cnt    <= 8'd0;
          pend_q <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              if (ev) begin
                state  <= PEND;
                pend_q <= 1'b1;
              end
            end
            PEND: begin
              if (ack) begin
                sack_q <= 1'b1;
                if (IS_EDGE && ev) begin
                  // fresh edge coincident with ack keeps the request alive
                  state  <= PEND;
                  pend_q <= 1'b1;
                end else begin
                  ovr_q  <= 1'b0;
                  pend_q <= 1'b0;
                  if (IS_EDGE) begin
                    state <= IDLE;
                  end else begin
                    state <= HOLD;
                    cnt   <= HOLD_LOAD;
                  end
                end
              end else if (IS_EDGE && ev) begin
                ovr_q <= 1'b1;
              end
            end
            HOLD: begin
              if (cnt == 8'd0) begin
                state <= IDLE;
              end else begin
                cnt <= cnt - 8'd1;
              end
            end
            default: begin
              state  <= IDLE;
              cnt    <= 8'd0;
              pend_q <= 1'b0;
            end
          endcase
        end
      end
    end

    assign pend_vec[k] = pend_q;
    assign ack_vec[k]  = sack_q;
    assign ovr_vec[k]  = ovr_q;
  end

  always_comb begin
    int_vec              = 8'd0;
    int_vec[NUM_SRC:1]   = pend_vec;
  end

  assign bus.int_in  = int_vec;
  assign bus.src_ack = ack_vec;
  assign bus.overrun = ovr_vec;

  // bit 0 and bits above NUM_SRC of the ack strobe have no source behind them
  assign unused_ack = ^bus.int_ack;

endmodule

`default_nettype wire

// File: tb/tb_mcu_irq_ctrl.sv
// ============================================================================
// Module   : tb_mcu_irq_ctrl
// Purpose  : Directed self-checking bench for mcu_irq_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mcu_irq_ctrl;

  localparam int         NUM_SRC   = 7;
  localparam logic [6:0] EDGE_MODE = 7'h7B;  // source 2 is level triggered
  localparam int         HOLDOFF   = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mcu_irq_ctrl_if #(.NUM_SRC(NUM_SRC)) bus ();

  mcu_irq_ctrl #(
    .NUM_SRC   (NUM_SRC),
    .EDGE_MODE (EDGE_MODE),
    .HOLDOFF   (HOLDOFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.src_in  = '0;
    bus.src_en  = '0;
    bus.int_ack = '0;
    tick();
    tick();
    checks++;
    if (bus.int_in !== 8'h00) begin
      errors++; $display("FAIL reset_int_in got %h expected %h", bus.int_in, 8'h00);
    end
    checks++;
    if (bus.src_ack !== 7'h00) begin
      errors++; $display("FAIL reset_src_ack got %h expected %h", bus.src_ack, 7'h00);
    end
    checks++;
    if (bus.overrun !== 7'h00) begin
      errors++; $display("FAIL reset_overrun got %h expected %h", bus.overrun, 7'h00);
    end
    reset = 1'b0;
    bus.src_en = 7'h7F;
    tick();
  endtask

  task automatic test_edge();
    bus.src_in = 7'h01;
    tick();
    checks++;
    if (bus.int_in !== 8'h02) begin
      errors++; $display("FAIL edge_pend got %h expected %h", bus.int_in, 8'h02);
    end
    bus.src_in = 7'h00;
    tick();
    checks++;
    if (bus.int_in !== 8'h02) begin
      errors++; $display("FAIL edge_hold got %h expected %h", bus.int_in, 8'h02);
    end
    bus.int_ack = 8'h02;
    tick();
    bus.int_ack = 8'h00;
    checks++;
    if (bus.int_in !== 8'h00) begin
      errors++; $display("FAIL edge_clear got %h expected %h", bus.int_in, 8'h00);
    end
    checks++;
    if (bus.src_ack !== 7'h01) begin
      errors++; $display("FAIL edge_src_ack got %h expected %h", bus.src_ack, 7'h01);
    end
    tick();
    checks++;
    if (bus.src_ack !== 7'h00) begin
      errors++; $display("FAIL edge_src_ack_pulse got %h expected %h", bus.src_ack, 7'h00);
    end
  endtask

  task automatic test_level_holdoff();
    int pulses;
    int early;
    bus.src_in = 7'h04;
    tick();
    checks++;
    if (bus.int_in !== 8'h08) begin
      errors++; $display("FAIL level_pend got %h expected %h", bus.int_in, 8'h08);
    end
    bus.int_ack = 8'h08;
    tick();  // cycle M+1
    bus.int_ack = 8'h00;
    pulses = (bus.src_ack == 7'h04) ? 1 : 0;
    early  = bus.int_in[3] ? 1 : 0;
    // cycles M+2 .. M+17 must stay low
    for (int i = 0; i < HOLDOFF; i++) begin
      tick();
      if (bus.src_ack != 7'h00) pulses++;
      if (bus.int_in[3]) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++; $display("FAIL level_holdoff_low got %0d expected %0d", early, 0);
    end
    tick();  // cycle M+18
    checks++;
    if (bus.int_in !== 8'h08) begin
      errors++; $display("FAIL level_rearm got %h expected %h", bus.int_in, 8'h08);
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL level_src_ack_count got %0d expected %0d", pulses, 1);
    end
    bus.src_in  = 7'h00;
    bus.int_ack = 8'h08;
    tick();
    bus.int_ack = 8'h00;
    repeat (HOLDOFF + 2) tick();
    checks++;
    if (bus.int_in !== 8'h00) begin
      errors++; $display("FAIL level_idle got %h expected %h", bus.int_in, 8'h00);
    end
  endtask

  task automatic test_overrun();
    bus.src_in = 7'h02;
    tick();
    bus.src_in = 7'h00;
    tick();
    bus.src_in = 7'h02;
    tick();
    bus.src_in = 7'h00;
    checks++;
    if (bus.overrun !== 7'h02) begin
      errors++; $display("FAIL overrun_set got %h expected %h", bus.overrun, 7'h02);
    end
    checks++;
    if (bus.int_in !== 8'h04) begin
      errors++; $display("FAIL overrun_int_in got %h expected %h", bus.int_in, 8'h04);
    end
    tick();
    bus.int_ack = 8'h04;
    tick();
    bus.int_ack = 8'h00;
    checks++;
    if (bus.overrun !== 7'h00) begin
      errors++; $display("FAIL overrun_clear got %h expected %h", bus.overrun, 7'h00);
    end
    checks++;
    if (bus.int_in !== 8'h00 || bus.src_ack !== 7'h02) begin
      errors++; $display("FAIL overrun_ack got %h/%h expected %h/%h",
                         bus.int_in, bus.src_ack, 8'h00, 7'h02);
    end
    tick();
  endtask

  task automatic test_ack_with_edge();
    bus.src_in = 7'h08;
    tick();
    bus.src_in = 7'h00;
    tick();
    bus.src_in  = 7'h08;
    bus.int_ack = 8'h10;
    tick();
    bus.src_in  = 7'h00;
    bus.int_ack = 8'h00;
    checks++;
    if (bus.int_in !== 8'h10) begin
      errors++; $display("FAIL ackedge_int_in got %h expected %h", bus.int_in, 8'h10);
    end
    checks++;
    if (bus.src_ack !== 7'h08) begin
      errors++; $display("FAIL ackedge_src_ack got %h expected %h", bus.src_ack, 7'h08);
    end
    checks++;
    if (bus.overrun !== 7'h00) begin
      errors++; $display("FAIL ackedge_overrun got %h expected %h", bus.overrun, 7'h00);
    end
    tick();
    bus.int_ack = 8'h10;
    tick();
    bus.int_ack = 8'h00;
    checks++;
    if (bus.int_in !== 8'h00) begin
      errors++; $display("FAIL ackedge_final got %h expected %h", bus.int_in, 8'h00);
    end
    tick();
  endtask

  task automatic test_disable();
    bus.src_in = 7'h10;
    tick();
    checks++;
    if (bus.int_in !== 8'h20) begin
      errors++; $display("FAIL disable_pend got %h expected %h", bus.int_in, 8'h20);
    end
    bus.src_in = 7'h00;
    bus.src_en = 7'h6F;
    tick();
    checks++;
    if (bus.int_in !== 8'h00 || bus.src_ack !== 7'h00) begin
      errors++; $display("FAIL disable_force got %h/%h expected %h/%h",
                         bus.int_in, bus.src_ack, 8'h00, 7'h00);
    end
    bus.int_ack = 8'h01;
    tick();
    bus.int_ack = 8'h00;
    checks++;
    if (bus.int_in !== 8'h00 || bus.src_ack !== 7'h00 || bus.overrun !== 7'h00) begin
      errors++; $display("FAIL ack_bit0 got %h/%h/%h expected %h/%h/%h",
                         bus.int_in, bus.src_ack, bus.overrun, 8'h00, 7'h00, 7'h00);
    end
    bus.src_en  = 7'h7F;
    bus.int_ack = 8'h20;
    tick();
    bus.int_ack = 8'h00;
    checks++;
    if (bus.src_ack !== 7'h00) begin
      errors++; $display("FAIL ack_idle got %h expected %h", bus.src_ack, 7'h00);
    end
  endtask

  task automatic test_multi_ack();
    bus.src_in = 7'h21;
    tick();
    bus.src_in = 7'h00;
    checks++;
    if (bus.int_in !== 8'h42) begin
      errors++; $display("FAIL multi_pend got %h expected %h", bus.int_in, 8'h42);
    end
    tick();
    bus.int_ack = 8'h42;
    tick();
    bus.int_ack = 8'h00;
    checks++;
    if (bus.int_in !== 8'h00 || bus.src_ack !== 7'h21) begin
      errors++; $display("FAIL multi_ack got %h/%h expected %h/%h",
                         bus.int_in, bus.src_ack, 8'h00, 7'h21);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.src_in = 7'h02;
    tick();
    bus.src_in = 7'h00;
    tick();
    bus.src_in = 7'h02;
    tick();
    bus.src_in = 7'h05;  // edge on src0, level on src2
    tick();
    checks++;
    if (bus.int_in !== 8'h0E || bus.overrun !== 7'h02) begin
      errors++; $display("FAIL mid_setup got %h/%h expected %h/%h",
                         bus.int_in, bus.overrun, 8'h0E, 7'h02);
    end
    bus.src_in  = 7'h04;
    bus.int_ack = 8'h08;
    tick();
    bus.int_ack = 8'h00;
    checks++;
    if (bus.int_in !== 8'h06 || bus.src_ack !== 7'h04) begin
      errors++; $display("FAIL mid_hold got %h/%h expected %h/%h",
                         bus.int_in, bus.src_ack, 8'h06, 7'h04);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.int_in !== 8'h00 || bus.src_ack !== 7'h00 || bus.overrun !== 7'h00) begin
      errors++; $display("FAIL mid_reset got %h/%h/%h expected %h/%h/%h",
                         bus.int_in, bus.src_ack, bus.overrun, 8'h00, 7'h00, 7'h00);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.int_in !== 8'h08) begin
      errors++; $display("FAIL post_reset_level got %h expected %h", bus.int_in, 8'h08);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_edge();
    test_level_holdoff();
    test_overrun();
    test_ack_with_edge();
    test_disable();
    test_multi_ack();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
